// File: rtl/mux_n_1_pipe.sv
// N-input registered select mux with valid/ready on both sides and a one-entry skid buffer.
// Optional out-of-range select checking is enabled by defining MUX_N_1_PIPE_SEL_CHECK_EN.
module mux_n_1_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        m_out,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   or_data_reg;
    logic [SEL_W-1:0]   or_sel_reg;
    logic               or_err_reg;
    logic [WIDTH-1:0]   sk_data_reg;
    logic [SEL_W-1:0]   sk_sel_reg;
    logic               sk_err_reg;

    logic [WIDTH-1:0]   chan [NUM_IN];
    logic               sel_oob;
    logic [SEL_W-1:0]   sel_eff;
    logic [WIDTH-1:0]   cap_data;
    logic [SEL_W-1:0]   cap_sel;
    logic               cap_err;
    logic               accept;
    logic               deliver;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
        assign chan[gi] = data_in[gi*WIDTH +: WIDTH];
    end

    // A power-of-two channel count cannot produce an out-of-range index.
    if ((1 << SEL_W) == NUM_IN) begin : g_sel_full
        assign sel_oob = 1'b0;
    end else begin : g_sel_partial
        assign sel_oob = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
    end

    assign sel_eff = sel_oob ? LAST_SEL : sel;

    always_comb begin
        cap_data = chan[sel_eff];
`ifdef MUX_N_1_PIPE_SEL_CHECK_EN
        if (sel_oob) begin
            cap_data = '0;
        end
        cap_sel = sel;
        cap_err = sel_oob;
`else
        cap_sel = sel_eff;
        cap_err = 1'b0;
`endif
    end

    assign accept  = in_valid && in_ready_reg;
    assign deliver = out_valid_reg && out_ready;

    // in_ready/out_valid are registered alongside the state so neither depends on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            or_data_reg   <= '0;
            or_sel_reg    <= '0;
            or_err_reg    <= 1'b0;
            sk_data_reg   <= '0;
            sk_sel_reg    <= '0;
            sk_err_reg    <= 1'b0;
        end else begin
            in_ready_reg <= (state_reg != TWO);
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        or_data_reg   <= cap_data;
                        or_sel_reg    <= cap_sel;
                        or_err_reg    <= cap_err;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        or_data_reg <= cap_data;
                        or_sel_reg  <= cap_sel;
                        or_err_reg  <= cap_err;
                    end else if (accept) begin
                        sk_data_reg  <= cap_data;
                        sk_sel_reg   <= cap_sel;
                        sk_err_reg   <= cap_err;
                        in_ready_reg <= 1'b0;
                        state_reg    <= TWO;
                    end else if (deliver) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        or_data_reg  <= sk_data_reg;
                        or_sel_reg   <= sk_sel_reg;
                        or_err_reg   <= sk_err_reg;
                        in_ready_reg <= 1'b1;
                        state_reg    <= ONE;
                    end else begin
                        in_ready_reg <= 1'b0;
                    end
                end
                default: begin
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    state_reg     <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign m_out     = or_data_reg;
    assign out_sel   = or_sel_reg;
    assign sel_err   = or_err_reg;

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Directed and randomized-stream bench for mux_n_1_pipe; honours MUX_N_1_PIPE_SEL_CHECK_EN
// for the out-of-range select expectations.
module tb_mux_n_1_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic rst;

    // Main instance: WIDTH=32, NUM_IN=4
    logic         iv, ir, ov, ordy, serr;
    logic [1:0]   sel, osel;
    logic [127:0] din;
    logic [31:0]  mo;

    // Out-of-range instance: WIDTH=16, NUM_IN=3
    logic         iv3, ir3, ov3, ordy3, serr3;
    logic [1:0]   sel3, osel3;
    logic [47:0]  din3;
    logic [15:0]  mo3;

    // Sweep instance A: WIDTH=8, NUM_IN=2
    logic         iv_a, ir_a, ov_a, ordy_a, serr_a;
    logic [0:0]   sel_a, osel_a;
    logic [15:0]  din_a;
    logic [7:0]   mo_a;

    // Sweep instance B: WIDTH=64, NUM_IN=16
    logic          iv_b, ir_b, ov_b, ordy_b, serr_b;
    logic [3:0]    sel_b, osel_b;
    logic [1023:0] din_b;
    logic [63:0]   mo_b;

    mux_n_1_pipe #(.WIDTH(32), .NUM_IN(4)) u_main (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir), .sel(sel), .data_in(din),
        .out_valid(ov), .out_ready(ordy), .m_out(mo), .out_sel(osel), .sel_err(serr)
    );

    mux_n_1_pipe #(.WIDTH(16), .NUM_IN(3)) u_oob (
        .clk(clk), .reset(rst), .in_valid(iv3), .in_ready(ir3), .sel(sel3), .data_in(din3),
        .out_valid(ov3), .out_ready(ordy3), .m_out(mo3), .out_sel(osel3), .sel_err(serr3)
    );

    mux_n_1_pipe #(.WIDTH(8), .NUM_IN(2)) u_a (
        .clk(clk), .reset(rst), .in_valid(iv_a), .in_ready(ir_a), .sel(sel_a), .data_in(din_a),
        .out_valid(ov_a), .out_ready(ordy_a), .m_out(mo_a), .out_sel(osel_a), .sel_err(serr_a)
    );

    mux_n_1_pipe #(.WIDTH(64), .NUM_IN(16)) u_b (
        .clk(clk), .reset(rst), .in_valid(iv_b), .in_ready(ir_b), .sel(sel_b), .data_in(din_b),
        .out_valid(ov_b), .out_ready(ordy_b), .m_out(mo_b), .out_sel(osel_b), .sel_err(serr_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic        acc_a, acc_b, del_a, del_b;
    logic        last_acc_a, last_acc_b;
    logic        drain;
    int          n_del_a, n_del_b;

    initial begin
        rst = 1'b1;
        iv = 0; sel = 0; ordy = 1; din = {32'h40, 32'h30, 32'h20, 32'h10};
        iv3 = 0; sel3 = 0; ordy3 = 1; din3 = {16'hABCD, 16'h2222, 16'h1111};
        iv_a = 0; sel_a = 0; ordy_a = 0; din_a = '0;
        iv_b = 0; sel_b = 0; ordy_b = 0; din_b = '0;

        // Reset state
        tick();
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_m_out", 64'(mo), 64'd0);
        chk("rst_out_sel", 64'(osel), 64'd0);
        chk("rst_sel_err", 64'(serr), 64'd0);
        chk("rst_in_ready", 64'(ir), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(ir), 64'd1);
        chk("post_rst_out_valid", 64'(ov), 64'd0);

        // Streaming: sel 2,0,3,1 -> 0x30,0x10,0x40,0x20 with no bubbles
        iv = 1; sel = 2;
        tick(); $display("stream beat0 m_out=%0h", mo);
        chk("stream0_valid", 64'(ov), 64'd1); chk("stream0_data", 64'(mo), 64'h30);
        sel = 0;
        tick(); $display("stream beat1 m_out=%0h", mo);
        chk("stream1_valid", 64'(ov), 64'd1); chk("stream1_data", 64'(mo), 64'h10);
        chk("stream1_ready", 64'(ir), 64'd1);
        sel = 3;
        tick(); $display("stream beat2 m_out=%0h", mo);
        chk("stream2_valid", 64'(ov), 64'd1); chk("stream2_data", 64'(mo), 64'h40);
        sel = 1;
        tick(); $display("stream beat3 m_out=%0h out_sel=%0d", mo, osel);
        chk("stream3_valid", 64'(ov), 64'd1); chk("stream3_data", 64'(mo), 64'h20);
        chk("stream3_sel", 64'(osel), 64'd1);
        iv = 0;
        tick();
        chk("stream_drained", 64'(ov), 64'd0);

        // Backpressure: A, B absorbed, C held
        ordy = 0; iv = 1; sel = 0;
        tick(); $display("bp accept A m_out=%0h in_ready=%0b", mo, ir);
        chk("bp_a_data", 64'(mo), 64'h10); chk("bp_a_ready", 64'(ir), 64'd1);
        sel = 1;
        tick(); $display("bp accept B m_out=%0h in_ready=%0b", mo, ir);
        chk("bp_b_ready", 64'(ir), 64'd0); chk("bp_b_data", 64'(mo), 64'h10);
        sel = 2;
        tick(); $display("bp hold C m_out=%0h in_ready=%0b", mo, ir);
        chk("bp_c_held_ready", 64'(ir), 64'd0); chk("bp_c_held_data", 64'(mo), 64'h10);
        ordy = 1;
        tick(); $display("bp deliver A, m_out=%0h in_ready=%0b", mo, ir);
        chk("bp_deliver_a_data", 64'(mo), 64'h20); chk("bp_deliver_a_ready", 64'(ir), 64'd1);
        tick(); $display("bp deliver B, m_out=%0h", mo);
        chk("bp_deliver_b_data", 64'(mo), 64'h30); chk("bp_deliver_b_valid", 64'(ov), 64'd1);
        iv = 0;
        tick(); $display("bp deliver C, out_valid=%0b", ov);
        chk("bp_deliver_c_empty", 64'(ov), 64'd0);

        // Output stability under backpressure while data_in toggles
        ordy = 0; iv = 1; sel = 3;
        tick();
        iv = 0;
        for (int i = 0; i < 5; i++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            sel = 2'($urandom_range(0, 3));
            tick(); $display("stable cycle %0d m_out=%0h out_sel=%0d", i, mo, osel);
            chk("stable_data", 64'(mo), 64'h40);
            chk("stable_sel", 64'(osel), 64'd3);
            chk("stable_valid", 64'(ov), 64'd1);
        end
        din = {32'h40, 32'h30, 32'h20, 32'h10};
        ordy = 1;
        tick();
        chk("stable_drained", 64'(ov), 64'd0);

        // Reset while in TWO discards both beats
        ordy = 0; iv = 1; sel = 0;
        tick();
        sel = 1;
        tick();
        chk("midrst_two", 64'(ir), 64'd0);
        iv = 0; rst = 1;
        tick(); $display("midrst during reset out_valid=%0b m_out=%0h in_ready=%0b", ov, mo, ir);
        chk("midrst_valid", 64'(ov), 64'd0); chk("midrst_data", 64'(mo), 64'd0);
        chk("midrst_ready", 64'(ir), 64'd0);
        rst = 0; ordy = 1;
        tick();
        chk("midrst_after_ready", 64'(ir), 64'd1); chk("midrst_after_valid", 64'(ov), 64'd0);
        tick();
        chk("midrst_no_ghost", 64'(ov), 64'd0);

        // Out-of-range select with NUM_IN=3
        iv3 = 1; sel3 = 3;
        tick(); $display("oob m_out=%0h sel_err=%0b out_sel=%0d", mo3, serr3, osel3);
        chk("oob_valid", 64'(ov3), 64'd1);
`ifdef MUX_N_1_PIPE_SEL_CHECK_EN
        chk("oob_data", 64'(mo3), 64'd0);
        chk("oob_err", 64'(serr3), 64'd1);
        chk("oob_sel", 64'(osel3), 64'd3);
`else
        chk("oob_data", 64'(mo3), 64'hABCD);
        chk("oob_err", 64'(serr3), 64'd0);
        chk("oob_sel", 64'(osel3), 64'd2);
`endif
        sel3 = 1;
        tick(); $display("inrange m_out=%0h sel_err=%0b out_sel=%0d", mo3, serr3, osel3);
        chk("inr_data", 64'(mo3), 64'h2222);
        chk("inr_err", 64'(serr3), 64'd0);
        chk("inr_sel", 64'(osel3), 64'd1);
        iv3 = 0;
        tick();
        chk("oob_drained", 64'(ov3), 64'd0);

        // Randomized sweep with scoreboard on both extreme configurations
        last_acc_a = 1'b1; last_acc_b = 1'b1;
        n_del_a = 0; n_del_b = 0;
        for (int cyc = 0; cyc < 10020; cyc++) begin
            drain = (cyc >= 10000);
            if (!(iv_a && !last_acc_a)) begin
                iv_a  = drain ? 1'b0 : 1'($urandom_range(0, 1));
                sel_a = 1'($urandom_range(0, 1));
                din_a = 16'($urandom);
            end
            if (!(iv_b && !last_acc_b)) begin
                iv_b  = drain ? 1'b0 : 1'($urandom_range(0, 1));
                sel_b = 4'($urandom_range(0, 15));
                for (int k = 0; k < 32; k++) din_b[k*32 +: 32] = $urandom;
            end
            ordy_a = drain ? 1'b1 : 1'($urandom_range(0, 1));
            ordy_b = drain ? 1'b1 : 1'($urandom_range(0, 1));
            acc_a = iv_a && ir_a; del_a = ov_a && ordy_a;
            acc_b = iv_b && ir_b; del_b = ov_b && ordy_b;
            if (del_a) begin
                if (qa.size() == 0) chk("sweep_a_extra_beat", 64'd1, 64'd0);
                else begin
                    chk("sweep_a_data", 64'(mo_a), qa.pop_front());
                    n_del_a++;
                end
            end
            if (del_b) begin
                if (qb.size() == 0) chk("sweep_b_extra_beat", 64'd1, 64'd0);
                else begin
                    chk("sweep_b_data", mo_b, qb.pop_front());
                    n_del_b++;
                end
            end
            if (acc_a) qa.push_back(64'(din_a[sel_a*8 +: 8]));
            if (acc_b) qb.push_back(din_b[sel_b*64 +: 64]);
            last_acc_a = acc_a; last_acc_b = acc_b;
            tick();
        end
        $display("sweep delivered a=%0d b=%0d", n_del_a, n_del_b);
        chk("sweep_a_leftover", 64'(qa.size()), 64'd0);
        chk("sweep_b_leftover", 64'(qb.size()), 64'd0);
        chk("sweep_a_progress", 64'(n_del_a > 1000), 64'd1);
        chk("sweep_b_progress", 64'(n_del_b > 1000), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_n_1_pipe.md
# mux_n_1_pipe

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready flow control on both sides. It is the pipelined successor of the datapath 2:1 select mux. It sits between the operand/forwarding sources and a pipeline stage register. It accepts one selected beat per cycle, holds it under backpressure via a one-entry skid buffer, and preserves beat order.

## Interface
- WIDTH, 32, data width of each input channel and of the output
- NUM_IN, 4, number of input channels; legal range 2..64
- SEL_W, $clog2(NUM_IN), derived localparam, not overridable
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream beat present
- in_ready  output  1  block can accept a beat this cycle
- sel  input  SEL_W  channel index for the current beat
- data_in  input  NUM_IN*WIDTH  flattened channels; channel i at [i*WIDTH +: WIDTH]
- out_valid  output  1  m_out/out_sel/sel_err hold a beat
- out_ready  input  1  downstream accepts the beat
- m_out  output  WIDTH  selected data
- out_sel  output  SEL_W  select index captured with the beat
- sel_err  output  1  beat was captured with an out-of-range sel (see Configuration)

## Operation
- Accept: in_valid && in_ready at a rising edge. The block captures data_in[sel*WIDTH +: WIDTH], sel, and the error flag.
- Deliver: out_valid && out_ready at a rising edge retires the output beat.
- Storage is an output register (OR) plus a skid register (SK). State machine:
  - EMPTY: OR and SK empty; out_valid=0, in_ready=1.
  - ONE: OR full; out_valid=1, in_ready=1.
  - TWO: OR and SK full; out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE; the beat is loaded into OR.
  - ONE + accept + deliver -> ONE; the new beat is loaded into OR.
  - ONE + accept, no deliver -> TWO; the new beat is loaded into SK.
  - ONE + deliver, no accept -> EMPTY.
  - TWO + deliver -> ONE; SK moves to OR. No accept is possible in TWO.
  - All other combinations hold the current state.
- Order is strictly FIFO. No beat is dropped or duplicated.
- Data captured from a channel is independent of later changes on data_in.
- sel is used only in the accept cycle.
- in_ready is a registered function of state. It never depends combinationally on out_ready.
- Upstream holds in_valid, sel, and data_in stable while in_valid && !in_ready.
- Downstream sees m_out, out_sel, and sel_err stable while out_valid && !out_ready.

## Timing
- Latency: a beat accepted at edge k shows out_valid=1 after edge k, and is deliverable at edge k+1.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- With out_ready=0, at most 2 beats are absorbed. in_ready falls the cycle after the second accept.
- Reset, sampled at an edge:
  - state goes to EMPTY; out_valid=0.
  - m_out=0, out_sel=0, sel_err=0, SK cleared.
  - in_ready=0 while reset is high, and 1 in the first cycle after it is released.
- Reset mid-operation discards all held beats. No partial delivery follows.
- Simultaneous accept and deliver in ONE is the normal streaming case. OR updates with no bubble.
- Out-of-range sel (sel >= NUM_IN) is possible only when NUM_IN is not a power of two. It is handled per Configuration.

## Configuration
- Macro: MUX_N_1_PIPE_SEL_CHECK_EN.
- Defined:
  - An out-of-range sel captures m_out=0 and sel_err=1 for that beat only.
  - The flag travels with the beat through OR/SK.
  - out_sel carries the raw sel.
- Undefined:
  - An out-of-range sel is clamped to channel NUM_IN-1.
  - out_sel carries NUM_IN-1.
  - sel_err is tied to 0.
- Handshake and timing are identical in both builds.

## Test plan
- Reset then stream, WIDTH=32, NUM_IN=4, out_ready=1. Inputs: channels 0..3 = 0x10,0x20,0x30,0x40; sel=2,0,3,1 on consecutive cycles. Required: m_out=0x30,0x10,0x40,0x20 on consecutive cycles, one cycle after each accept, with no bubbles.
- Backpressure: hold out_ready=0 and present 3 beats (A,B,C). Required: A and B accepted; in_ready=0 in the cycle after B; C held. Release out_ready: deliver A,B,C in order; in_ready returns to 1 after the first delivery.
- Output stability: out_ready=0 for 5 cycles while data_in toggles every cycle. Required: m_out and out_sel stay constant; out_valid stays 1.
- Reset mid-operation: in state TWO, assert reset for 1 cycle. Required: out_valid=0, m_out=0, in_ready=0 during reset, in_ready=1 the next cycle; the held beats are never delivered.
- Out-of-range sel, NUM_IN=3, sel=3, channel 2 = 0xABCD:
  - With MUX_N_1_PIPE_SEL_CHECK_EN: m_out=0, sel_err=1, out_sel=3.
  - Without it: m_out=0xABCD, sel_err=0, out_sel=2.
- Width/depth sweep, WIDTH=8 with NUM_IN=2, and WIDTH=64 with NUM_IN=16. Random in_valid/out_ready at 50% each over 10k cycles. Required: scoreboard order and data match, with no loss or duplication.
